s298_unfolded_core: RTL and testbench

// - Full-scan "unfolded" combinational view of the s298-class sequential benchmark: the

---
 rtl/s298_unfolded_core.sv | 111 +++++++++++
 tb/tb_s298_unfolded_core.sv | 126 ++++++++++++
 2 files changed

// File: rtl/s298_unfolded_core.sv
// Unfolded (full-scan) combinational view of an s298-class circuit: the present state
// enters on ppi, the next state leaves on ppo, and everything is built from gate primitives.
module s298_unfolded_core (
  input  logic clk,
  input  logic rst,
  input  logic g0, g1, g2,
  output logic po0, po1, po2, po3, po4, po5,
  input  logic ppi0, ppi1, ppi2, ppi3, ppi4, ppi5, ppi6, ppi7, ppi8, ppi9,
  input  logic ppi10, ppi11, ppi12, ppi13, ppi14, ppi15, ppi16, ppi17, ppi18, ppi19,
  input  logic ppi20, ppi21, ppi22, ppi23, ppi24,
  output logic ppo0, ppo1, ppo2, ppo3, ppo4, ppo5, ppo6, ppo7, ppo8, ppo9,
  output logic ppo10, ppo11, ppo12, ppo13, ppo14, ppo15, ppo16, ppo17, ppo18, ppo19,
  output logic ppo20, ppo21, ppo22, ppo23, ppo24
);

  wire        unused_clk;
  wire        rst_n, g0_n, g2_n;
  wire [7:0]  c, sum, nc;
  wire [8:0]  cy;
  wire [5:0]  k, nk;
  wire [10:0] a, ck, na;
  wire        k0x, c_any, c_zero, m0, m1;
  wire [5:0]  raw_po, po_v;
  wire [24:0] raw_ppo, ppo_v;

  assign unused_clk = clk;

  assign c = {ppi7, ppi6, ppi5, ppi4, ppi3, ppi2, ppi1, ppi0};
  assign k = {ppi13, ppi12, ppi11, ppi10, ppi9, ppi8};
  assign a = {ppi24, ppi23, ppi22, ppi21, ppi20, ppi19, ppi18, ppi17, ppi16, ppi15, ppi14};

  not u_rst_n (rst_n, rst);
  not u_g0_n  (g0_n, g0);
  not u_g2_n  (g2_n, g2);

  // Ripple incrementer: carry-in is the count enable, carry-out doubles as po0.
  buf u_cy0 (cy[0], g1);
  genvar i;
  for (i = 0; i < 8; i++) begin : g_cnt
    xor u_sum (sum[i], c[i], cy[i]);
    and u_cy  (cy[i+1], c[i], cy[i]);
    and u_clr (nc[i], g0_n, sum[i]);
  end

  // Ring rotate-left; clear loads 6'b000001, so bit 0 is OR-forced rather than masked.
  xor u_k0x (k0x, k[5], g2);
  or  u_k0  (nk[0], g0, k0x);
  for (i = 1; i < 6; i++) begin : g_ring
    and u_rot (nk[i], g0_n, k[i-1]);
  end

  assign ck = {c, k[2:0]};
  for (i = 0; i < 11; i++) begin : g_acc
    xor u_acc (na[i], a[i], ck[i]);
  end

  buf u_po0 (raw_po[0], cy[8]);
  xor u_po1 (raw_po[1], k[0], k[1], k[2], k[3], k[4], k[5]);
  or  u_po2 (raw_po[2], a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8], a[9], a[10]);
  or  u_cany (c_any, c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7]);
  not u_cz  (c_zero, c_any);
  or  u_po3 (raw_po[3], g0, c_zero);
  and u_m1  (m1, g2, k[5]);
  and u_m0  (m0, g2_n, k[0]);
  or  u_po4 (raw_po[4], m1, m0);
  xor u_po5 (raw_po[5], g0, g1, g2, a[0]);

  assign raw_ppo = {na, nk, nc};

  // Reset is a plain AND gate on every output, so it acts without any clock.
  for (i = 0; i < 6; i++) begin : g_gpo
    and u_gpo (po_v[i], rst_n, raw_po[i]);
  end
  for (i = 0; i < 25; i++) begin : g_gppo
    and u_gppo (ppo_v[i], rst_n, raw_ppo[i]);
  end

  assign po0 = po_v[0];
  assign po1 = po_v[1];
  assign po2 = po_v[2];
  assign po3 = po_v[3];
  assign po4 = po_v[4];
  assign po5 = po_v[5];

  assign ppo0  = ppo_v[0];
  assign ppo1  = ppo_v[1];
  assign ppo2  = ppo_v[2];
  assign ppo3  = ppo_v[3];
  assign ppo4  = ppo_v[4];
  assign ppo5  = ppo_v[5];
  assign ppo6  = ppo_v[6];
  assign ppo7  = ppo_v[7];
  assign ppo8  = ppo_v[8];
  assign ppo9  = ppo_v[9];
  assign ppo10 = ppo_v[10];
  assign ppo11 = ppo_v[11];
  assign ppo12 = ppo_v[12];
  assign ppo13 = ppo_v[13];
  assign ppo14 = ppo_v[14];
  assign ppo15 = ppo_v[15];
  assign ppo16 = ppo_v[16];
  assign ppo17 = ppo_v[17];
  assign ppo18 = ppo_v[18];
  assign ppo19 = ppo_v[19];
  assign ppo20 = ppo_v[20];
  assign ppo21 = ppo_v[21];
  assign ppo22 = ppo_v[22];
  assign ppo23 = ppo_v[23];
  assign ppo24 = ppo_v[24];

endmodule

// File: tb/tb_s298_unfolded_core.sv
// Bench for s298_unfolded_core: directed boundary vectors plus random vectors,
// all checked against an arithmetic model of the counter/ring/accumulator.
module tb_s298_unfolded_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  g;
  logic [24:0] ppi;
  wire  [5:0]  po;
  wire  [24:0] ppo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  s298_unfolded_core dut (
    .clk(clk), .rst(rst), .g0(g[0]), .g1(g[1]), .g2(g[2]),
    .po0(po[0]), .po1(po[1]), .po2(po[2]), .po3(po[3]), .po4(po[4]), .po5(po[5]),
    .ppi0(ppi[0]), .ppi1(ppi[1]), .ppi2(ppi[2]), .ppi3(ppi[3]), .ppi4(ppi[4]),
    .ppi5(ppi[5]), .ppi6(ppi[6]), .ppi7(ppi[7]), .ppi8(ppi[8]), .ppi9(ppi[9]),
    .ppi10(ppi[10]), .ppi11(ppi[11]), .ppi12(ppi[12]), .ppi13(ppi[13]), .ppi14(ppi[14]),
    .ppi15(ppi[15]), .ppi16(ppi[16]), .ppi17(ppi[17]), .ppi18(ppi[18]), .ppi19(ppi[19]),
    .ppi20(ppi[20]), .ppi21(ppi[21]), .ppi22(ppi[22]), .ppi23(ppi[23]), .ppi24(ppi[24]),
    .ppo0(ppo[0]), .ppo1(ppo[1]), .ppo2(ppo[2]), .ppo3(ppo[3]), .ppo4(ppo[4]),
    .ppo5(ppo[5]), .ppo6(ppo[6]), .ppo7(ppo[7]), .ppo8(ppo[8]), .ppo9(ppo[9]),
    .ppo10(ppo[10]), .ppo11(ppo[11]), .ppo12(ppo[12]), .ppo13(ppo[13]), .ppo14(ppo[14]),
    .ppo15(ppo[15]), .ppo16(ppo[16]), .ppo17(ppo[17]), .ppo18(ppo[18]), .ppo19(ppo[19]),
    .ppo20(ppo[20]), .ppo21(ppo[21]), .ppo22(ppo[22]), .ppo23(ppo[23]), .ppo24(ppo[24])
  );

  // Reference: integer arithmetic on the three state fields.
  function automatic logic [30:0] model(input logic r, input logic [2:0] gi, input logic [24:0] s);
    int cc, kk, aa, ncv, nkv, nav;
    logic [5:0] p;
    cc = int'(s[7:0]);
    kk = int'(s[13:8]);
    aa = int'(s[24:14]);
    ncv = gi[0] ? 0 : (cc + int'(gi[1])) % 256;
    nkv = gi[0] ? 1 : ((((kk * 2) % 64) + (kk / 32)) ^ int'(gi[2]));
    nav = aa ^ ((cc * 8) + (kk % 8));
    p[0] = (cc == 255) && gi[1];
    p[1] = ^s[13:8];
    p[2] = (aa != 0);
    p[3] = gi[0] || (cc == 0);
    p[4] = gi[2] ? s[13] : s[8];
    p[5] = gi[0] ^ gi[1] ^ gi[2] ^ s[14];
    if (r) return 31'd0;
    return {p, nav[10:0], nkv[5:0], ncv[7:0]};
  endfunction

  task automatic apply(input logic r, input logic [2:0] gi, input logic [24:0] s, input string tag);
    logic [30:0] e;
    rst = r; g = gi; ppi = s;
    #1;
    e = model(r, gi, s);
    tests++;
    assert (po === e[30:25]) else begin
      fails++;
      $error("FAIL %s po got %b expected %b", tag, po, e[30:25]);
    end
    tests++;
    assert (ppo === e[24:0]) else begin
      fails++;
      $error("FAIL %s ppo got %h expected %h", tag, ppo, e[24:0]);
    end
  endtask

  task automatic lit(input logic [30:0] got, input logic [30:0] exp, input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset dominates with everything at one.
    apply(1'b1, 3'b111, {25{1'b1}}, "reset_all_ones");
    lit({po, ppo}, 31'd0, "reset_literal");
    apply(1'b0, 3'b111, {25{1'b1}}, "reset_release");

    // Counter wrap: C=FF, K=0, A=0, g1=1.
    apply(1'b0, 3'b010, {11'd0, 6'd0, 8'hFF}, "wrap");
    lit({po, ppo}, {6'b100001, 11'h7F8, 6'd0, 8'h00}, "wrap_literal");

    // Clear overrides count enable and mode.
    apply(1'b0, 3'b111, {11'd0, 6'b101010, 8'h5A}, "clear");
    lit({po[5:3], ppo}, {3'b111, 11'h2D2, 6'b000001, 8'h00}, "clear_literal");

    // Count enable on/off.
    apply(1'b0, 3'b010, {11'd0, 6'd0, 8'h12}, "count_en");
    lit({7'd0, ppo[7:0]}, {7'd0, 8'h13}, "count_en_literal");
    apply(1'b0, 3'b000, {11'd0, 6'd0, 8'h12}, "count_hold");
    lit({6'd0, po[0], ppo[7:0]}, {6'd0, 1'b0, 8'h12}, "count_hold_literal");

    // Ring rotate with mode XOR cancelling the wrapped bit.
    apply(1'b0, 3'b100, {11'd0, 6'b100000, 8'h01}, "ring_mode");
    lit({po[5:3], po[1], ppo[13:8]}, {3'b110, 1'b1, 6'b000000}, "ring_mode_literal");

    // Ring at zero with mode off stays zero.
    apply(1'b0, 3'b000, {11'h155, 6'd0, 8'h80}, "ring_zero");

    // Random vectors, including forced corner fields.
    for (int n = 0; n < 300; n++) begin
      logic [24:0] s;
      logic [2:0]  gi;
      s  = 25'($urandom);
      gi = 3'($urandom);
      if (n % 10 == 1) s[7:0] = 8'hFF;
      if (n % 10 == 2) s[7:0] = 8'h00;
      if (n % 10 == 3) s[24:14] = 11'd0;
      if (n % 10 == 4) s[13:8] = 6'd0;
      apply(1'b0, gi, s, "random");
    end

    // Reset asserted over random inputs.
    for (int n = 0; n < 20; n++) begin
      apply(1'b1, 3'($urandom), 25'($urandom), "random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
